// File: rtl/ft_pkg.sv
// Shared types and debug-port constants for the fault-recovery restore sequencer.
package ft_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HALT_REQ,
    HALT_WAIT,
    DRAIN,
    GPR_WAIT,
    NPC_REQ,
    NPC_WAIT,
    RES_REQ,
    RES_WAIT
  } ft_dbg_state_e;

  localparam logic [14:0] DBG_CTRL_ADDR = 15'h0000;
  localparam logic [14:0] DBG_GPR_BASE  = 15'h0400;
  localparam logic [14:0] DBG_NPC_ADDR  = 15'h2000;
  localparam logic [31:0] DBG_HALT_BIT  = 32'h0001_0000;

endpackage

// File: rtl/ft_sync_fifo.sv
// First-word-fall-through synchronous FIFO; also exposes the entry behind the head
// so the consumer can chain back-to-back requests.
module ft_sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         dout_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push at full is only taken when the head leaves in the same cycle.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign dout      = mem[rd_ptr];
  assign dout_next = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ft_dbg_restore.sv
// Turns halt / register-stream / resume recovery events into ordered, single-outstanding
// debug-port writes: halt core, rewrite GPRs, write NPC, resume core.
module ft_dbg_restore
  import ft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DBG_ADDR_WIDTH = 15,
  parameter int unsigned FIFO_DEPTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      halt_i,
  input  logic                      shift_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      resume_i,
  input  logic [DATA_WIDTH-1:0]     spc_i,
  output logic                      dbg_req_o,
  input  logic                      dbg_gnt_i,
  input  logic                      dbg_rvalid_i,
  output logic                      dbg_we_o,
  output logic [DBG_ADDR_WIDTH-1:0] dbg_addr_o,
  output logic [DATA_WIDTH-1:0]     dbg_wdata_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  ft_dbg_state_e         state;
  logic [DATA_WIDTH-1:0] npc_q;
  logic                  res_pend;
  logic                  active;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic [ENTRY_W-1:0]    head;
  logic [ENTRY_W-1:0]    head_next;
  logic [CNT_W-1:0]      count;

  function automatic logic [DBG_ADDR_WIDTH-1:0] gpr_addr(input logic [ENTRY_W-1:0] e);
    return DBG_ADDR_WIDTH'(DBG_GPR_BASE) + DBG_ADDR_WIDTH'({e[ENTRY_W-1 -: ADDR_WIDTH], 2'b00});
  endfunction

  assign active   = (state != IDLE);
  assign push     = active && shift_i;
  assign pop      = (state == GPR_WAIT) && !dbg_req_o && dbg_rvalid_i;
  assign flush    = (state == RES_WAIT) && dbg_rvalid_i;
  assign dbg_we_o = dbg_req_o;

  ft_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .din       ({addr_i, data_i}),
    .dout      (head),
    .dout_next (head_next),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Sequencer; a low req inside a *_WAIT state means the grant has already happened.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      dbg_req_o   <= 1'b0;
      dbg_addr_o  <= '0;
      dbg_wdata_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
      npc_q       <= '0;
      res_pend    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (active) begin
        if (resume_i) begin
          res_pend <= 1'b1;
          npc_q    <= spc_i;
        end
        if (shift_i && full && !pop) overflow_o <= 1'b1;
      end
      case (state)
        IDLE: if (halt_i) begin
          state       <= HALT_REQ;
          dbg_req_o   <= 1'b1;
          dbg_addr_o  <= DBG_ADDR_WIDTH'(DBG_CTRL_ADDR);
          dbg_wdata_o <= DATA_WIDTH'(DBG_HALT_BIT);
          busy_o      <= 1'b1;
          overflow_o  <= 1'b0;
        end
        HALT_REQ: if (dbg_gnt_i) begin
          dbg_req_o <= 1'b0;
          state     <= HALT_WAIT;
        end
        HALT_WAIT: if (dbg_rvalid_i) state <= DRAIN;
        DRAIN: begin
          if (!empty) begin
            dbg_req_o   <= 1'b1;
            dbg_addr_o  <= gpr_addr(head);
            dbg_wdata_o <= head[DATA_WIDTH-1:0];
            state       <= GPR_WAIT;
          end else if (res_pend) begin
            dbg_req_o   <= 1'b1;
            dbg_addr_o  <= DBG_ADDR_WIDTH'(DBG_NPC_ADDR);
            dbg_wdata_o <= npc_q;
            state       <= NPC_REQ;
          end
        end
        GPR_WAIT: begin
          if (dbg_req_o) begin
            if (dbg_gnt_i) dbg_req_o <= 1'b0;
          end else if (dbg_rvalid_i) begin
            // Chain straight into the next queued register to keep one write per two cycles.
            if (count >= CNT_W'(2)) begin
              dbg_req_o   <= 1'b1;
              dbg_addr_o  <= gpr_addr(head_next);
              dbg_wdata_o <= head_next[DATA_WIDTH-1:0];
            end else begin
              state <= DRAIN;
            end
          end
        end
        NPC_REQ: if (dbg_gnt_i) begin
          dbg_req_o <= 1'b0;
          state     <= NPC_WAIT;
        end
        NPC_WAIT: if (dbg_rvalid_i) begin
          dbg_req_o   <= 1'b1;
          dbg_addr_o  <= DBG_ADDR_WIDTH'(DBG_CTRL_ADDR);
          dbg_wdata_o <= '0;
          state       <= RES_REQ;
        end
        RES_REQ: if (dbg_gnt_i) begin
          dbg_req_o <= 1'b0;
          state     <= RES_WAIT;
        end
        RES_WAIT: if (dbg_rvalid_i) begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          res_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_dbg_restore.sv
// Bench for ft_dbg_restore: a 32-deep instance for ordering/timing and a 4-deep one for overflow,
// each driven by a simple debug-port responder and checked against a queue of expected writes.
module tb_ft_dbg_restore;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned DAW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, halt, shift, resume;
  logic [AW-1:0] addr;
  logic [DW-1:0] data, spc;

  logic           req_a, gnt_a, rv_a, we_a, busy_a, done_a, ovf_a;
  logic [DAW-1:0] daddr_a;
  logic [DW-1:0]  wdata_a;
  logic           req_b, gnt_b, rv_b, we_b, busy_b, done_b, ovf_b;
  logic [DAW-1:0] daddr_b;
  logic [DW-1:0]  wdata_b;

  ft_dbg_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBG_ADDR_WIDTH(DAW), .FIFO_DEPTH(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .shift_i(shift), .addr_i(addr), .data_i(data),
    .resume_i(resume), .spc_i(spc), .dbg_req_o(req_a), .dbg_gnt_i(gnt_a), .dbg_rvalid_i(rv_a),
    .dbg_we_o(we_a), .dbg_addr_o(daddr_a), .dbg_wdata_o(wdata_a), .busy_o(busy_a),
    .done_o(done_a), .overflow_o(ovf_a));

  ft_dbg_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBG_ADDR_WIDTH(DAW), .FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .shift_i(shift), .addr_i(addr), .data_i(data),
    .resume_i(resume), .spc_i(spc), .dbg_req_o(req_b), .dbg_gnt_i(gnt_b), .dbg_rvalid_i(rv_b),
    .dbg_we_o(we_b), .dbg_addr_o(daddr_b), .dbg_wdata_o(wdata_b), .busy_o(busy_b),
    .done_o(done_b), .overflow_o(ovf_b));

  // Responders: grant after stall_a waiting cycles (A) or when enabled (B); rvalid one cycle later.
  int   stall_a = 0;
  int   wait_a  = 0;
  int   cyc     = 0;
  logic gnt_en_b = 1'b1;
  logic stray_a  = 1'b0;
  logic rvq_a = 1'b0, rvq_b = 1'b0;

  assign gnt_a = req_a && (wait_a >= stall_a);
  assign gnt_b = req_b && gnt_en_b;
  assign rv_a  = rvq_a | stray_a;
  assign rv_b  = rvq_b;

  always @(posedge clk) begin
    wait_a <= (req_a && !gnt_a) ? wait_a + 1 : 0;
    rvq_a  <= gnt_a;
    rvq_b  <= gnt_b;
    cyc    <= cyc + 1;
  end

  typedef struct {
    logic [DAW-1:0] addr;
    logic [DW-1:0]  wdata;
    logic           we;
    int             cyc;
  } txn_t;

  txn_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  logic mon_a = 1'b1, mon_b = 1'b0;
  int   done_cnt_a = 0, done_cnt_b = 0;

  // Monitor: record every accepted request, count done pulses.
  always @(negedge clk) begin
    if (mon_a && req_a && gnt_a) obs_a.push_back('{daddr_a, wdata_a, we_a, cyc});
    if (mon_b && req_b && gnt_b) obs_b.push_back('{daddr_b, wdata_b, we_b, cyc});
    if (done_a) done_cnt_a = done_cnt_a + 1;
    if (done_b) done_cnt_b = done_cnt_b + 1;
  end

  int total = 0, bad = 0;
  int track_gap = 0, last_gpr = -1, max_gap = 0, n_gpr = 0;

  typedef struct {
    logic [AW-1:0]  idx;
    logic [DW-1:0]  val;
    logic [DAW-1:0] exp_addr;
    logic [DW-1:0]  exp_data;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_a(input logic [DAW-1:0] a, input logic [DW-1:0] d);
    exp_a.push_back('{a, d, 1'b1, 0});
  endtask

  task automatic expect_b(input logic [DAW-1:0] a, input logic [DW-1:0] d);
    exp_b.push_back('{a, d, 1'b1, 0});
  endtask

  task automatic drain();
    txn_t o, e;
    while (obs_a.size() > 0) begin
      o = obs_a.pop_front();
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_txn_a: got addr=%h data=%h want none", o.addr, o.wdata);
      end else begin
        e = exp_a.pop_front();
        chk("txn_a_addr", 64'(o.addr), 64'(e.addr));
        chk("txn_a_wdata", 64'(o.wdata), 64'(e.wdata));
        chk("txn_a_we", 64'(o.we), 64'(e.we));
        if (track_gap != 0 && o.addr >= 15'h0400 && o.addr < 15'h0480) begin
          if (last_gpr >= 0 && o.cyc - last_gpr > max_gap) max_gap = o.cyc - last_gpr;
          last_gpr = o.cyc;
          n_gpr++;
        end
      end
    end
    while (obs_b.size() > 0) begin
      o = obs_b.pop_front();
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_txn_b: got addr=%h data=%h want none", o.addr, o.wdata);
      end else begin
        e = exp_b.pop_front();
        chk("txn_b_addr", 64'(o.addr), 64'(e.addr));
        chk("txn_b_wdata", 64'(o.wdata), 64'(e.wdata));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic wait_idle(input bit sel_b, input int budget, input string nm);
    int n = 0;
    while ((sel_b ? busy_b : busy_a) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_finished"}, 64'(sel_b ? busy_b : busy_a), 64'(0));
    step();
    step();
    chk({nm, "_exp_left"}, 64'(sel_b ? exp_b.size() : exp_a.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
    step();
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
  endtask

  task automatic pulse_resume(input logic [DW-1:0] pc);
    resume = 1'b1;
    spc    = pc;
    step();
    resume = 1'b0;
  endtask

  initial begin
    int d0, n;
    logic [DAW-1:0] sa;
    logic [DW-1:0]  sw;

    tbl[0] = '{5'd31, 32'hFFFF_FFFF, 15'h047C, 32'hFFFF_FFFF};
    tbl[1] = '{5'd0,  32'h0000_0000, 15'h0400, 32'h0000_0000};
    tbl[2] = '{5'd7,  32'h1234_5678, 15'h041C, 32'h1234_5678};
    tbl[3] = '{5'd16, 32'hA5A5_A5A5, 15'h0440, 32'hA5A5_A5A5};
    tbl[4] = '{5'd1,  32'h8000_0001, 15'h0404, 32'h8000_0001};
    tbl[5] = '{5'd30, 32'h0F0F_0000, 15'h0478, 32'h0F0F_0000};

    rst = 1'b1; halt = 1'b0; shift = 1'b0; resume = 1'b0;
    addr = '0; data = '0; spc = '0;
    step(); step(); step();
    rst = 1'b0;
    step();

    // Reset values
    chk("rst_req", 64'(req_a), 64'(0));
    chk("rst_we", 64'(we_a), 64'(0));
    chk("rst_addr", 64'(daddr_a), 64'(0));
    chk("rst_wdata", 64'(wdata_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_ovf", 64'(ovf_a), 64'(0));

    // Halt: request on the cycle after the pulse
    d0 = done_cnt_a;
    expect_a(15'h0000, 32'h0001_0000);
    pulse_halt();
    chk("halt_req", 64'(req_a), 64'(1));
    chk("halt_addr", 64'(daddr_a), 64'(15'h0000));
    chk("halt_wdata", 64'(wdata_a), 64'(32'h0001_0000));
    chk("halt_we", 64'(we_a), 64'(1));
    chk("halt_busy", 64'(busy_a), 64'(1));
    expect_a(15'h2000, 32'h0000_1234);
    expect_a(15'h0000, 32'h0);
    pulse_resume(32'h0000_1234);
    wait_idle(1'b0, 50, "halt_only");
    chk("halt_only_done", 64'(done_cnt_a - d0), 64'(1));

    // Full 32-register restore at full throughput
    do_reset();
    d0 = done_cnt_a;
    track_gap = 1; last_gpr = -1; max_gap = 0; n_gpr = 0;
    expect_a(15'h0000, 32'h0001_0000);
    pulse_halt();
    for (int i = 0; i < 32; i++) begin
      shift = 1'b1;
      addr  = AW'(i);
      data  = DW'(i * 10);
      expect_a(15'h0400 + DAW'(i * 4), DW'(i * 10));
      step();
    end
    shift = 1'b0;
    expect_a(15'h2000, 32'h80);
    expect_a(15'h0000, 32'h0);
    pulse_resume(32'h80);
    wait_idle(1'b0, 300, "full_restore");
    track_gap = 0;
    chk("full_done_once", 64'(done_cnt_a - d0), 64'(1));
    chk("full_ovf", 64'(ovf_a), 64'(0));
    chk("full_gpr_count", 64'(n_gpr), 64'(32));
    chk("full_gpr_period", 64'(max_gap), 64'(2));

    // Stalled grant on a GPR write
    do_reset();
    expect_a(15'h0000, 32'h0001_0000);
    pulse_halt();
    step(); step(); step(); step();
    stall_a = 5;
    expect_a(15'h040C, 32'hDEAD_BEEF);
    shift = 1'b1; addr = 5'd3; data = 32'hDEAD_BEEF;
    step();
    shift = 1'b0;
    n = 0;
    while (!req_a && n < 20) begin step(); n++; end
    chk("stall_req_seen", 64'(req_a), 64'(1));
    sa = daddr_a;
    sw = wdata_a;
    chk("stall_addr", 64'(sa), 64'(15'h040C));
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("stall_hold_%0d", k), {31'd0, req_a, daddr_a, wdata_a}, {31'd0, 1'b1, sa, sw});
      if (k < 5) chk($sformatf("stall_gnt_%0d", k), 64'(gnt_a), 64'(0));
    end
    step();
    chk("stall_req_drop", 64'(req_a), 64'(0));
    stall_a = 0;
    expect_a(15'h2000, 32'h0000_0040);
    expect_a(15'h0000, 32'h0);
    pulse_resume(32'h0000_0040);
    wait_idle(1'b0, 60, "stall");

    // Overflow on the 4-deep instance
    mon_a = 1'b0;
    mon_b = 1'b1;
    do_reset();
    d0 = done_cnt_b;
    gnt_en_b = 1'b0;
    expect_b(15'h0000, 32'h0001_0000);
    pulse_halt();
    for (int i = 0; i < 6; i++) begin
      shift = 1'b1;
      addr  = AW'(i);
      data  = 32'h100 + DW'(i);
      if (i < 4) expect_b(15'h0400 + DAW'(i * 4), 32'h100 + DW'(i));
      step();
      if (i == 3) chk("ovf_at_exact_full", 64'(ovf_b), 64'(0));
      if (i == 4) chk("ovf_first_drop", 64'(ovf_b), 64'(1));
    end
    shift = 1'b0;
    expect_b(15'h2000, 32'h4444);
    expect_b(15'h0000, 32'h0);
    pulse_resume(32'h4444);
    gnt_en_b = 1'b1;
    wait_idle(1'b1, 80, "overflow");
    chk("ovf_sticky", 64'(ovf_b), 64'(1));
    chk("ovf_done_once", 64'(done_cnt_b - d0), 64'(1));
    expect_b(15'h0000, 32'h0001_0000);
    pulse_halt();
    chk("ovf_clear_on_halt", 64'(ovf_b), 64'(0));
    expect_b(15'h2000, 32'h55);
    expect_b(15'h0000, 32'h0);
    pulse_resume(32'h55);
    wait_idle(1'b1, 60, "ovf_rerun");
    mon_b = 1'b0;
    mon_a = 1'b1;

    // Early resume while entries are queued, second resume overwrites the PC
    do_reset();
    stall_a = 3;
    expect_a(15'h0000, 32'h0001_0000);
    pulse_halt();
    for (int i = 0; i < 6; i++) begin
      shift  = 1'b1;
      addr   = tbl[i].idx;
      data   = tbl[i].val;
      resume = (i == 3);
      spc    = 32'h100;
      expect_a(tbl[i].exp_addr, tbl[i].exp_data);
      step();
    end
    shift  = 1'b0;
    resume = 1'b0;
    chk("early_entries_pending", 64'(exp_a.size() >= 4), 64'(1));
    expect_a(15'h2000, 32'h244);
    expect_a(15'h0000, 32'h0);
    pulse_resume(32'h244);
    wait_idle(1'b0, 200, "early_resume");
    stall_a = 0;

    // Reset mid-transaction drops req asynchronously; stray rvalid afterwards is ignored
    do_reset();
    stall_a = 1000;
    pulse_halt();
    shift = 1'b1; addr = 5'd9; data = 32'h99;
    step();
    addr = 5'd10; data = 32'hAA;
    step();
    shift = 1'b0;
    chk("midrst_req_before", 64'(req_a), 64'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_req_async", 64'(req_a), 64'(0));
    chk("midrst_busy_async", 64'(busy_a), 64'(0));
    step();
    rst = 1'b0;
    stall_a = 0;
    exp_a.delete(); obs_a.delete();
    step();
    stray_a = 1'b1;
    step();
    stray_a = 1'b0;
    step();
    chk("stray_rv_req", 64'(req_a), 64'(0));
    chk("stray_rv_busy", 64'(busy_a), 64'(0));
    expect_a(15'h0000, 32'h0001_0000);
    expect_a(15'h2000, 32'h600);
    expect_a(15'h0000, 32'h0);
    pulse_halt();
    pulse_resume(32'h600);
    wait_idle(1'b0, 60, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ft_dbg_restore.md
# ft_dbg_restore

Debug-bus sequencer downstream of `ft_module`. It converts the fault-recovery events (`halt`, per-register `shift` stream, `resume` with the saved PC) into ordered single-outstanding write transactions on a RI5CY-style debug port. The sequence is halt core, rewrite GPRs, write NPC, resume core. It sits between `ft_module` and the debug unit of the core being restored, and buffers the non-backpressurable register stream in a FIFO.

## Interface

- `ADDR_WIDTH`, 5, GPR index width
- `DATA_WIDTH`, 32, register/PC width
- `DBG_ADDR_WIDTH`, 15, debug address width
- `FIFO_DEPTH`, 32, restore-FIFO entries (power of two, ≥2)

Ports:
- `clk_i`  in  1  clock. One clock domain only.
- `rst_i`  in  1  reset, asynchronous, active-high
- `halt_i`  in  1  single-cycle start-of-recovery pulse from `ft_module`
- `shift_i`  in  1  `addr_i`/`data_i` valid this cycle
- `addr_i`  in  ADDR_WIDTH  GPR index to restore
- `data_i`  in  DATA_WIDTH  GPR value to restore
- `resume_i`  in  1  single-cycle end-of-stream pulse
- `spc_i`  in  DATA_WIDTH  saved PC, sampled with `resume_i`
- `dbg_req_o`  out  1  transaction request
- `dbg_gnt_i`  in  1  request accepted
- `dbg_rvalid_i`  in  1  transaction complete
- `dbg_we_o`  out  1  always 1 while `dbg_req_o` is high
- `dbg_addr_o`  out  DBG_ADDR_WIDTH  debug address
- `dbg_wdata_o`  out  DATA_WIDTH  write data
- `busy_o`  out  1  state ≠ IDLE
- `done_o`  out  1  one-cycle pulse when the sequence completes
- `overflow_o`  out  1  sticky flag: a shift was dropped because the FIFO was full

## Operation

- States: IDLE, HALT_REQ, HALT_WAIT, DRAIN, GPR_WAIT, NPC_REQ, NPC_WAIT, RES_REQ, RES_WAIT.
- **IDLE:**
  - `halt_i` → HALT_REQ.
  - `halt_i` also clears `overflow_o`.
  - `shift_i` and `resume_i` are ignored in IDLE.
- **Halt write:** address `0x0000`, data `0x0001_0000`. On `rvalid`, go to DRAIN.
- **Shift capture:**
  - In any non-IDLE state, `shift_i` pushes `{addr_i, data_i}` into the FIFO.
  - When the FIFO is full and no pop occurs that cycle, the entry is dropped and `overflow_o` is set.
  - Push and pop in the same cycle at full is legal.
- **Resume capture:**
  - In any non-IDLE state, `resume_i` sets `res_pend` and captures `spc_i` into `npc_q`.
  - A second `resume_i` overwrites `npc_q`.
- **DRAIN:**
  - FIFO non-empty → issue GPR write: address `0x0400 + {idx, 2'b00}`, data = entry. Go to GPR_WAIT.
  - GPR_WAIT pops the FIFO on `rvalid` and returns to DRAIN.
  - FIFO empty and `res_pend` set → NPC_REQ.
  - Otherwise stay in DRAIN.
- **NPC write:** address `0x2000`, data `npc_q`.
- **Resume write:** address `0x0000`, data `0`.
- **Completion:**
  - On `rvalid` in RES_WAIT → IDLE.
  - `done_o` pulses, `res_pend` clears.
  - Any residual FIFO entries are flushed.
- `halt_i` outside IDLE is ignored.

## Timing

- **Reset values:** all outputs 0 (`dbg_req_o`, `dbg_we_o`, `dbg_addr_o`, `dbg_wdata_o`, `busy_o`, `done_o`, `overflow_o`); FIFO empty; state IDLE. Reset mid-transaction drops `dbg_req_o` asynchronously.
- **Request outputs:** all request outputs are registered.
  - `halt_i` at cycle N → `dbg_req_o` high at N+1.
- **Request hold:** `dbg_req_o`, `dbg_addr_o` and `dbg_wdata_o` stay stable until the cycle in which `dbg_gnt_i` is high. `dbg_req_o` deasserts the following cycle.
- **Completion handshake:**
  - `dbg_rvalid_i` is accepted no earlier than the cycle after grant.
  - Exactly one transaction is outstanding at a time.
- **Throughput:** with grant in the same cycle as req and `rvalid` one cycle later, one GPR write every 2 cycles.
  - DRAIN → next req is registered, so the next req appears on the cycle after `rvalid`.
  - FIFO_DEPTH=32 absorbs a full 32-register burst.
- **Done pulse:** `done_o` is high for the single cycle after the final `rvalid`. `busy_o` falls in the same cycle.
- **FIFO occupancy:** FIFO count is `$clog2(FIFO_DEPTH)+1` bits. Pointers wrap modulo FIFO_DEPTH.

## Structure

- Package `ft_pkg`:
  - state enum `ft_dbg_state_e`
  - constants `DBG_CTRL_ADDR=15'h0000`, `DBG_GPR_BASE=15'h0400`, `DBG_NPC_ADDR=15'h2000`, `DBG_HALT_BIT=32'h0001_0000`
- Sub-module `ft_sync_fifo`, parameterised by width and depth:
  - ports: push, pop, full, empty, flush, dout
  - first-word-fall-through
- Top level holds the FSM, `npc_q`, `res_pend` and `overflow_o`.

## Test plan

1. **Halt:** `halt_i` pulse, grant tied high → `dbg_req_o` at cycle +1 with addr `0x0000`, wdata `0x0001_0000`, we=1; `busy_o`=1.
2. **Full restore:** 32 consecutive shifts with `addr_i`=i, `data_i`=i*10, then `resume_i` with `spc_i`=`0x80`. Required response:
   - 32 writes in order to `0x0400+4i` with data i*10
   - then `0x2000`/`0x80`, then `0x0000`/`0`
   - `done_o` pulses once; `overflow_o`=0
3. **Stalled grant:** `dbg_gnt_i` low for 5 cycles during a GPR write → addr/wdata/req unchanged across all 5 cycles; the entry is written exactly once.
4. **Overflow:** FIFO_DEPTH=4, grant held low, 6 shifts → `overflow_o`=1; after release, only entries 0–3 are written; next `halt_i` clears the flag.
5. **Early resume:** `resume_i` arrives while 3 entries are still queued → NPC write happens only after the 3rd GPR write completes.
6. **Reset mid-transaction:** `rst_i` asserted while `dbg_req_o`=1 → `dbg_req_o` drops without waiting for a clock edge. After release: IDLE, FIFO empty; a stray `rvalid` is ignored.
